// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C bus arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } arb_state_e;

    localparam logic REQ_CMD   = 1'b0;
    localparam logic REQ_POLL  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // Fields captured from a requester on a valid/ready transfer
    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       mode;
        logic       lock;
    } i2c_req_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle counter shared by the WAIT and HOLD phases; pulses when the
// enabled count sits at its final value.
module arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q;

    // Count enabled cycles, restarting from zero whenever cleared
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between the command path and the poll sequencer.
// One transaction at a time; a lock keeps the bus with its owner for a
// follow-up transaction (e.g. control-byte write then read).
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CMD_BURST_MAX  = 4,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_mode,
    input  logic       cmd_lock,
    output logic       cmd_done,
    output logic [7:0] cmd_rdata,
    output logic       cmd_timeout,
    input  logic       poll_valid,
    output logic       poll_ready,
    input  logic [6:0] poll_addr,
    input  logic [7:0] poll_wdata,
    input  logic       poll_mode,
    input  logic       poll_lock,
    output logic       poll_done,
    output logic [7:0] poll_rdata,
    output logic       poll_timeout,
    output logic [6:0] sensorAddr_I2C,
    output logic [7:0] writeVal_I2C,
    output logic       mode_I2C,
    output logic       start_I2C,
    input  logic [7:0] readVal_I2C,
    input  logic       dataRdy_I2C,
    output logic       busy,
    output logic       owner
);

    localparam int BW = $clog2(CMD_BURST_MAX + 1);

    arb_state_e  state_q;
    logic        owner_q;
    logic        lock_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        mode_q;
    logic        start_q;
    logic [BW-1:0] burst_q;
    logic        cmd_done_q, cmd_to_q, poll_done_q, poll_to_q;
    logic [7:0]  cmd_rdata_q, poll_rdata_q;

    logic        poll_wins_s;
    logic        cmd_xfer_s, poll_xfer_s, xfer_s;
    i2c_req_t    req_s;
    logic        to_en_s, to_exp_s;

    // Arbitration result and ready generation
    always_comb begin
        poll_wins_s = 1'b0;
        cmd_ready   = 1'b0;
        poll_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Poll gets through once cmd has used up its burst allowance
                poll_wins_s = poll_valid &&
                              (!cmd_valid || (burst_q == BW'(CMD_BURST_MAX)));
                cmd_ready   = cmd_valid && !poll_wins_s;
                poll_ready  = poll_wins_s;
            end
            ST_HOLD: begin
                cmd_ready  = cmd_valid  && (owner_q == REQ_CMD);
                poll_ready = poll_valid && (owner_q == REQ_POLL);
            end
            default: begin
                poll_wins_s = 1'b0;
                cmd_ready   = 1'b0;
                poll_ready  = 1'b0;
            end
        endcase
    end

    assign cmd_xfer_s  = cmd_valid  && cmd_ready;
    assign poll_xfer_s = poll_valid && poll_ready;
    assign xfer_s      = cmd_xfer_s || poll_xfer_s;

    // Select the fields of whichever requester is transferring
    always_comb begin
        if (poll_xfer_s) begin
            req_s = '{addr: poll_addr, wdata: poll_wdata, mode: poll_mode, lock: poll_lock};
        end else begin
            req_s = '{addr: cmd_addr, wdata: cmd_wdata, mode: cmd_mode, lock: cmd_lock};
        end
    end

    assign to_en_s = (state_q == ST_WAIT) || (state_q == ST_HOLD);

    arb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clock    (clock),
        .rst_n    (rst_n),
        .clr_i    (!to_en_s),
        .en_i     (to_en_s),
        .expire_o (to_exp_s)
    );

    // Arbiter FSM with registered I2C drive and per-requester responses
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_CMD;
            lock_q       <= 1'b0;
            addr_q       <= 7'd0;
            wdata_q      <= 8'd0;
            mode_q       <= I2C_WRITE;
            start_q      <= 1'b0;
            burst_q      <= '0;
            cmd_done_q   <= 1'b0;
            cmd_to_q     <= 1'b0;
            poll_done_q  <= 1'b0;
            poll_to_q    <= 1'b0;
            cmd_rdata_q  <= 8'd0;
            poll_rdata_q <= 8'd0;
        end else begin
            start_q     <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_to_q    <= 1'b0;
            poll_done_q <= 1'b0;
            poll_to_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!poll_valid || poll_xfer_s) begin
                        burst_q <= '0;
                    end else if (cmd_xfer_s) begin
                        burst_q <= burst_q + BW'(1);
                    end
                    if (xfer_s) begin
                        owner_q <= poll_xfer_s;
                        addr_q  <= req_s.addr;
                        wdata_q <= req_s.wdata;
                        mode_q  <= req_s.mode;
                        lock_q  <= req_s.lock;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the expiry cycle still counts as success
                    if (dataRdy_I2C) begin
                        if (owner_q == REQ_POLL) begin
                            poll_rdata_q <= readVal_I2C;
                            poll_done_q  <= 1'b1;
                        end else begin
                            cmd_rdata_q <= readVal_I2C;
                            cmd_done_q  <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end else if (to_exp_s) begin
                        if (owner_q == REQ_POLL) begin
                            poll_rdata_q <= 8'd0;
                            poll_done_q  <= 1'b1;
                            poll_to_q    <= 1'b1;
                        end else begin
                            cmd_rdata_q <= 8'd0;
                            cmd_done_q  <= 1'b1;
                            cmd_to_q    <= 1'b1;
                        end
                        lock_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    addr_q  <= 7'd0;
                    wdata_q <= 8'd0;
                    mode_q  <= I2C_WRITE;
                    state_q <= lock_q ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    // Only the owner can be ready here, so owner_q is unchanged
                    if (xfer_s) begin
                        addr_q  <= req_s.addr;
                        wdata_q <= req_s.wdata;
                        mode_q  <= req_s.mode;
                        lock_q  <= req_s.lock;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else if (to_exp_s) begin
                        lock_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sensorAddr_I2C = addr_q;
    assign writeVal_I2C   = wdata_q;
    assign mode_I2C       = mode_q;
    assign start_I2C      = start_q;
    assign cmd_done       = cmd_done_q;
    assign cmd_timeout    = cmd_to_q;
    assign cmd_rdata      = cmd_rdata_q;
    assign poll_done      = poll_done_q;
    assign poll_timeout   = poll_to_q;
    assign poll_rdata     = poll_rdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign owner          = owner_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized bench for i2c_bus_arbiter. The bench acts as both requesters
// and as the I2C master, and predicts every cycle from a transaction
// timeline: grant, start one cycle later, completion chosen by the bench.
module tb_i2c_bus_arbiter;

    localparam int T    = 16;
    localparam int BMAX = 4;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_mode, cmd_lock, cmd_done, cmd_timeout;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata, cmd_rdata;
    logic       poll_valid, poll_ready, poll_mode, poll_lock, poll_done, poll_timeout;
    logic [6:0] poll_addr;
    logic [7:0] poll_wdata, poll_rdata;
    logic [6:0] sensorAddr_I2C;
    logic [7:0] writeVal_I2C, readVal_I2C;
    logic       mode_I2C, start_I2C, dataRdy_I2C, busy, owner;

    int n_cmp = 0;
    int n_err = 0;

    // Requester-side reference state (index 0 = cmd, 1 = poll)
    logic       pend[2];
    logic [6:0] r_addr[2];
    logic [7:0] r_wdata[2];
    logic       r_mode[2];
    logic       r_lock[2];
    logic [7:0] rdata_exp[2];
    int         burst;
    bit         force_both;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(T), .CMD_BURST_MAX(BMAX)) dut (
        .clock(clock), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_mode(cmd_mode), .cmd_lock(cmd_lock),
        .cmd_done(cmd_done), .cmd_rdata(cmd_rdata), .cmd_timeout(cmd_timeout),
        .poll_valid(poll_valid), .poll_ready(poll_ready), .poll_addr(poll_addr),
        .poll_wdata(poll_wdata), .poll_mode(poll_mode), .poll_lock(poll_lock),
        .poll_done(poll_done), .poll_rdata(poll_rdata), .poll_timeout(poll_timeout),
        .sensorAddr_I2C(sensorAddr_I2C), .writeVal_I2C(writeVal_I2C),
        .mode_I2C(mode_I2C), .start_I2C(start_I2C), .readVal_I2C(readVal_I2C),
        .dataRdy_I2C(dataRdy_I2C), .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_req();
        cmd_valid  = pend[0]; cmd_addr  = r_addr[0]; cmd_wdata  = r_wdata[0];
        cmd_mode   = r_mode[0]; cmd_lock = r_lock[0];
        poll_valid = pend[1]; poll_addr = r_addr[1]; poll_wdata = r_wdata[1];
        poll_mode  = r_mode[1]; poll_lock = r_lock[1];
    endtask

    task automatic new_req(input int r, input bit allow_lock);
        r_addr[r]  = 7'($urandom);
        r_wdata[r] = 8'($urandom);
        r_mode[r]  = 1'($urandom);
        r_lock[r]  = allow_lock && ($urandom_range(0, 2) == 0);
        pend[r]    = 1'b1;
    endtask

    task automatic check_bus(input string tag, input logic b, input logic s,
                             input logic [6:0] a, input logic [7:0] wd, input logic m);
        check_eq({tag, ".busy"},  busy, b);
        check_eq({tag, ".start"}, start_I2C, s);
        check_eq({tag, ".addr"},  sensorAddr_I2C, a);
        check_eq({tag, ".wdata"}, writeVal_I2C, wd);
        check_eq({tag, ".mode"},  mode_I2C, m);
    endtask

    // w = requester expected to see done this cycle, or -1 for none
    task automatic check_resp(input string tag, input int w, input logic to);
        check_eq({tag, ".cmd_done"},     cmd_done,     w == 0);
        check_eq({tag, ".poll_done"},    poll_done,    w == 1);
        check_eq({tag, ".cmd_timeout"},  cmd_timeout,  (w == 0) && to);
        check_eq({tag, ".poll_timeout"}, poll_timeout, (w == 1) && to);
        check_eq({tag, ".cmd_rdata"},    cmd_rdata,    rdata_exp[0]);
        check_eq({tag, ".poll_rdata"},   poll_rdata,   rdata_exp[1]);
    endtask

    task automatic check_ready(input string tag, input logic c, input logic p);
        check_eq({tag, ".cmd_ready"},  cmd_ready,  c);
        check_eq({tag, ".poll_ready"}, poll_ready, p);
    endtask

    // Entered at the negedge of the first ISSUE cycle after a grant to w.
    // Returns at the negedge of the first IDLE cycle after the bus is released.
    task automatic do_txn(input int w, input logic [6:0] fa, input logic [7:0] fw,
                          input logic fm, input logic fl);
        logic [7:0] rv;
        logic       to;
        int         d, k;
        bit         more;
        more = 1'b1;
        while (more) begin
            // ISSUE: start strobe with captured fields; dataRdy here is ignored
            drive_req();
            dataRdy_I2C = 1'($urandom);
            #1;
            check_bus("issue", 1'b1, 1'b1, fa, fw, fm);
            check_eq("issue.owner", owner, w);
            check_ready("issue", 1'b0, 1'b0);
            check_resp("issue", -1, 1'b0);
            case ($urandom_range(0, 3))
                0:       d = -1;
                1:       d = T - 1;
                default: d = $urandom_range(0, 8);
            endcase
            rv = 8'd0;
            cycle();
            // WAIT: master completes after d cycles, or never
            for (int j = 0; j < T; j++) begin
                drive_req();
                readVal_I2C = 8'($urandom);
                dataRdy_I2C = (j == d);
                if (j == d) rv = readVal_I2C;
                #1;
                check_bus("wait", 1'b1, 1'b0, fa, fw, fm);
                check_ready("wait", 1'b0, 1'b0);
                check_resp("wait", -1, 1'b0);
                if (j == d || j == T - 1) break;
                cycle();
            end
            to = (d < 0);
            rdata_exp[w] = to ? 8'd0 : rv;
            cycle();
            // DONE: one-cycle response to the owner
            drive_req();
            dataRdy_I2C = 1'($urandom);
            readVal_I2C = 8'($urandom);
            #1;
            check_bus("done", 1'b1, 1'b0, fa, fw, fm);
            check_ready("done", 1'b0, 1'b0);
            check_resp("done", w, to);
            cycle();
            if (!fl || to) begin
                more = 1'b0;
            end else begin
                // HOLD: owner may follow up at cycle k, else the bus is released
                k = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, T - 1);
                for (int h = 0; h < T; h++) begin
                    if (h == k) new_req(w, 1'b1);
                    drive_req();
                    dataRdy_I2C = 1'($urandom);
                    #1;
                    check_bus("hold", 1'b1, 1'b0, 7'd0, 8'd0, 1'b0);
                    check_eq("hold.owner", owner, w);
                    check_ready("hold", (w == 0) && (h == k), (w == 1) && (h == k));
                    check_resp("hold", -1, 1'b0);
                    cycle();
                    if (h == k) break;
                end
                if (k >= 0) begin
                    pend[w] = 1'b0;
                    fa = r_addr[w]; fw = r_wdata[w]; fm = r_mode[w]; fl = r_lock[w];
                end else begin
                    more = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int w;
        pend = '{1'b0, 1'b0};
        r_addr = '{7'd0, 7'd0}; r_wdata = '{8'd0, 8'd0};
        r_mode = '{1'b0, 1'b0}; r_lock = '{1'b0, 1'b0};
        rdata_exp = '{8'd0, 8'd0};
        burst = 0;
        drive_req();
        readVal_I2C = 8'd0;
        dataRdy_I2C = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        check_bus("reset", 1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
        check_eq("reset.owner", owner, 1'b0);
        check_resp("reset", -1, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;

        for (int it = 0; it < 120; it++) begin
            force_both = (it < 30);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && (force_both || $urandom_range(0, 3) != 0))
                    new_req(r, !force_both);
            end
            drive_req();
            dataRdy_I2C = 1'($urandom);
            #1;
            check_bus("idle", 1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
            check_resp("idle", -1, 1'b0);
            if (pend[1] && (!pend[0] || burst == BMAX)) w = 1;
            else if (pend[0]) w = 0;
            else w = -1;
            check_ready("idle", w == 0, w == 1);
            if (pend[1] && w == 0) burst++;
            else burst = 0;
            cycle();
            if (w >= 0) begin
                pend[w] = 1'b0;
                do_txn(w, r_addr[w], r_wdata[w], r_mode[w], r_lock[w]);
            end
        end

        // Asynchronous reset in the middle of a transaction
        pend = '{1'b0, 1'b0};
        drive_req();
        cycle();
        new_req(0, 1'b0);
        drive_req();
        cycle();
        pend[0] = 1'b0;
        drive_req();
        dataRdy_I2C = 1'b0;
        cycle();
        #1;
        check_bus("rst_wait", 1'b1, 1'b0, r_addr[0], r_wdata[0], r_mode[0]);
        rst_n = 1'b0;
        #1;
        check_bus("rst_async", 1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
        check_eq("rst_async.owner", owner, 1'b0);
        rdata_exp = '{8'd0, 8'd0};
        check_resp("rst_async", -1, 1'b0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dataRdy_I2C = 1'b1;
            readVal_I2C = 8'hC3;
            cycle();
            #1;
            check_bus("post_rst", 1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
            check_resp("post_rst", -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the run never reaches its summary
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
